// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded operands and control, decodes the
// ALU control field, forwards EX/MEM and MEM/WB results onto the ALU operands
// and flags load-use hazards so the front end can hold for one cycle.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [5:0]  id_funct,
  input  logic [1:0]  id_alu_op,
  input  logic        id_reg_dst,
  input  logic        id_alu_src,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        id_reg_write,
  input  logic        flush,
  input  logic        exmem_reg_write,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [2:0]  ex_ctl,
  output logic [4:0]  ex_shamt,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_wr_reg,
  output logic        ex_valid,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic        ex_reg_write,
  output logic        hazard_stall
);

  localparam logic [2:0] CTL_AND = 3'b000;
  localparam logic [2:0] CTL_OR  = 3'b001;
  localparam logic [2:0] CTL_ADD = 3'b010;
  localparam logic [2:0] CTL_SLL = 3'b011;
  localparam logic [2:0] CTL_SUB = 3'b110;
  localparam logic [2:0] CTL_SLT = 3'b111;

  logic        vld_p1;
  logic [31:0] rs_data_p1, rt_data_p1, imm_p1;
  logic [4:0]  shamt_p1, rs_p1, rt_p1, wr_reg_p1;
  logic [2:0]  ctl_p1;
  logic        alu_src_p1, mem_read_p1, mem_write_p1, mem_to_reg_p1, reg_write_p1;
  logic [31:0] fwd_rs, fwd_rt;

  // ALUOp/funct to 3-bit ALU control; unknown funct falls back to add.
  function automatic logic [2:0] alu_ctl(input logic [1:0] op, input logic [5:0] funct);
    logic [2:0] c;
    c = CTL_ADD;
    case (op)
      2'b00: c = CTL_ADD;
      2'b01: c = CTL_SUB;
      2'b11: c = CTL_OR;
      default: begin
        case (funct)
          6'b100000: c = CTL_ADD;
          6'b100010: c = CTL_SUB;
          6'b100100: c = CTL_AND;
          6'b100101: c = CTL_OR;
          6'b101010: c = CTL_SLT;
          6'b000000: c = CTL_SLL;
          default:   c = CTL_ADD;
        endcase
      end
    endcase
    return c;
  endfunction

  // Forwarding mux for one operand: EX/MEM beats MEM/WB, and $0 never forwards.
  function automatic logic [31:0] fwd_sel(
    input logic [4:0]  idx,
    input logic [31:0] latched,
    input logic        em_we,
    input logic [4:0]  em_rd,
    input logic [31:0] em_val,
    input logic        mw_we,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_val
  );
    if (em_we && em_rd != 5'd0 && em_rd == idx)      return em_val;
    else if (mw_we && mw_rd != 5'd0 && mw_rd == idx) return mw_val;
    else                                             return latched;
  endfunction

  // Load-use detection against the instruction currently sitting in ID.
  always_comb begin
    hazard_stall = vld_p1 & mem_read_p1 & (wr_reg_p1 != 5'd0) & id_valid &
                   ((wr_reg_p1 == id_rs) | (wr_reg_p1 == id_rt));
  end

  // ---- ID -> EX stage boundary ----
  // Capture the ID instruction, or insert a bubble on flush/stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= 1'b0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      shamt_p1      <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      wr_reg_p1     <= '0;
      ctl_p1        <= '0;
      alu_src_p1    <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      reg_write_p1  <= 1'b0;
    end else if (flush || hazard_stall) begin
      vld_p1        <= 1'b0;
      rs_data_p1    <= '0;
      rt_data_p1    <= '0;
      imm_p1        <= '0;
      shamt_p1      <= '0;
      rs_p1         <= '0;
      rt_p1         <= '0;
      wr_reg_p1     <= '0;
      ctl_p1        <= '0;
      alu_src_p1    <= 1'b0;
      mem_read_p1   <= 1'b0;
      mem_write_p1  <= 1'b0;
      mem_to_reg_p1 <= 1'b0;
      reg_write_p1  <= 1'b0;
    end else begin
      vld_p1        <= id_valid;
      rs_data_p1    <= id_rs_data;
      rt_data_p1    <= id_rt_data;
      imm_p1        <= id_imm;
      shamt_p1      <= id_shamt;
      rs_p1         <= id_rs;
      rt_p1         <= id_rt;
      wr_reg_p1     <= id_reg_dst ? id_rd : id_rt;
      ctl_p1        <= alu_ctl(id_alu_op, id_funct);
      alu_src_p1    <= id_valid & id_alu_src;
      mem_read_p1   <= id_valid & id_mem_read;
      mem_write_p1  <= id_valid & id_mem_write;
      mem_to_reg_p1 <= id_valid & id_mem_to_reg;
      reg_write_p1  <= id_valid & id_reg_write;
    end
  end

  // Same-cycle operand forwarding and ALU operand selection; sll shifts rt.
  always_comb begin
    fwd_rs = fwd_sel(rs_p1, rs_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                     memwb_reg_write, memwb_rd, memwb_result);
    fwd_rt = fwd_sel(rt_p1, rt_data_p1, exmem_reg_write, exmem_rd, exmem_result,
                     memwb_reg_write, memwb_rd, memwb_result);
    ex_a          = (ctl_p1 == CTL_SLL) ? fwd_rt : fwd_rs;
    ex_b          = alu_src_p1 ? imm_p1 : fwd_rt;
    ex_store_data = fwd_rt;
  end

  assign ex_ctl        = ctl_p1;
  assign ex_shamt      = shamt_p1;
  assign ex_wr_reg     = wr_reg_p1;
  assign ex_valid      = vld_p1;
  assign ex_mem_read   = mem_read_p1;
  assign ex_mem_write  = mem_write_p1;
  assign ex_mem_to_reg = mem_to_reg_p1;
  assign ex_reg_write  = reg_write_p1;

endmodule
